// File: rtl/clint_timer_if.sv
// clint_timer_if: request/response register port of clint_timer (slave = timer, master = bus agent)
interface clint_timer_if;
  logic req_valid_in;
  logic req_ready_out;
  logic req_we_in;
  logic [4:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic rsp_valid_out;
  logic rsp_ready_in;
  logic [31:0] rsp_rdata_out;
  logic rsp_err_out;
  modport slave(
    input req_valid_in, req_we_in, req_addr_in, req_wdata_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
  );
  modport master(
    output req_valid_in, req_we_in, req_addr_in, req_wdata_in, rsp_ready_in,
    input req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
  );
endinterface

// File: rtl/clint_timer.sv
// clint_timer: CLINT subset (mtime, mtimecmp, msip -> MTIP/MSIP); define CLINT_MTIME_SNAPSHOT_EN for a tear-free mtime hi shadow
module clint_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_in,
  input  logic reset_n_in,
  clint_timer_if.slave bus,
  output logic mip_mtip_out,
  output logic mip_msip_out
);
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [15:0] pre_q, pre_d;
  logic msip_q, msip_d, mtip_q;
  logic rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d, rd_val, hi_rd;
  logic [2:0] sel;
  logic acc, taken, hit, wr, rd, wr_lo, wr_hi, tick;
  assign sel = bus.req_addr_in[4:2];
  assign hit = (bus.req_addr_in[1:0] == 2'd0) && (sel <= 3'd4);
  assign acc = bus.req_valid_in & bus.req_ready_out;
  assign taken = rsp_valid_q & bus.rsp_ready_in;
  assign wr = acc & bus.req_we_in & hit;
  assign rd = acc & ~bus.req_we_in & hit;
  assign wr_lo = wr && sel == 3'd3;
  assign wr_hi = wr && sel == 3'd4;
  assign tick = pre_q == 16'(PRESCALE - 1);
`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] shadow_q;
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) shadow_q <= '0;
    else if (rd && sel == 3'd3) shadow_q <= mtime_q[63:32];
  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif
  assign rd_val = sel == 3'd0 ? {31'd0, msip_q} :
                  sel == 3'd1 ? mtimecmp_q[31:0] :
                  sel == 3'd2 ? mtimecmp_q[63:32] :
                  sel == 3'd3 ? mtime_q[31:0] : hi_rd;
  always_comb begin
    pre_d = (wr_lo | wr_hi | tick) ? 16'd0 : pre_q + 16'd1;
    mtime_d = wr_lo ? {mtime_q[63:32], bus.req_wdata_in} :
              wr_hi ? {bus.req_wdata_in, mtime_q[31:0]} :
              tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = (wr && sel == 3'd1) ? {mtimecmp_q[63:32], bus.req_wdata_in} :
                 (wr && sel == 3'd2) ? {bus.req_wdata_in, mtimecmp_q[31:0]} : mtimecmp_q;
    msip_d = (wr && sel == 3'd0) ? bus.req_wdata_in[0] : msip_q;
    rsp_valid_d = acc | (rsp_valid_q & ~bus.rsp_ready_in);
    rdata_d = acc ? (rd ? rd_val : 32'd0) : taken ? 32'd0 : rdata_q;
    err_d = acc ? ~hit : taken ? 1'b0 : err_q;
  end
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      mtime_q <= '0;
      mtimecmp_q <= '1;
      pre_q <= '0;
      msip_q <= 1'b0;
      mtip_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pre_q <= pre_d;
      msip_q <= msip_d;
      mtip_q <= mtime_q >= mtimecmp_q;
      rsp_valid_q <= rsp_valid_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign bus.req_ready_out = ~rsp_valid_q | bus.rsp_ready_in;
  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_rdata_out = rdata_q;
  assign bus.rsp_err_out = err_q;
  assign mip_mtip_out = mtip_q;
  assign mip_msip_out = msip_q;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed self-checking bench for clint_timer with PRESCALE = 1
module tb_clint_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mtip, msip;
  logic v, er;
  logic [31:0] r, r0;
  int pass_cnt = 0;
  int total = 0;
  clint_timer_if bus();
  clint_timer #(.PRESCALE(1)) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .bus(bus),
    .mip_mtip_out(mtip),
    .mip_msip_out(msip)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d,
                       output logic ov, output logic [31:0] or_, output logic oe);
    bus.req_valid_in = 1'b1;
    bus.req_we_in = we;
    bus.req_addr_in = a;
    bus.req_wdata_in = d;
    tick();
    bus.req_valid_in = 1'b0;
    bus.req_we_in = 1'b0;
    ov = bus.rsp_valid_out;
    or_ = bus.rsp_rdata_out;
    oe = bus.rsp_err_out;
  endtask
  task automatic test_reset();
    logic [31:0] r1, r2;
    #12;
    total++; if (bus.req_ready_out !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready_out); else pass_cnt++;
    total++; if (bus.rsp_valid_out !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid_out); else pass_cnt++;
    total++; if ({mtip, msip, bus.rsp_err_out} !== 3'b000) $display("FAIL reset_irq_err got %b want 000", {mtip, msip, bus.rsp_err_out}); else pass_cnt++;
    total++; if (bus.rsp_rdata_out !== 32'd0) $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata_out); else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 5'h0C, 32'd0, v, r1, er);
    issue(1'b0, 5'h0C, 32'd0, v, r2, er);
    total++; if (r1 !== 32'd0) $display("FAIL reset_mtime_first got %h want 0", r1); else pass_cnt++;
    total++; if (r2 - r1 !== 32'd1) $display("FAIL reset_mtime_delta got %h want 1", r2 - r1); else pass_cnt++;
    total++; if ({v, er, mtip} !== 3'b100) $display("FAIL reset_read_flags got %b want 100", {v, er, mtip}); else pass_cnt++;
  endtask
  task automatic test_timer_fire();
    issue(1'b1, 5'h0C, 32'd0, v, r, er);
    issue(1'b1, 5'h08, 32'd0, v, r, er);
    issue(1'b1, 5'h04, 32'd40, v, r, er);
    repeat (38) tick();
    total++; if (mtip !== 1'b0) $display("FAIL fire_early got %b want 0", mtip); else pass_cnt++;
    tick();
    total++; if (mtip !== 1'b1) $display("FAIL fire_rise got %b want 1", mtip); else pass_cnt++;
    repeat (5) tick();
    total++; if (mtip !== 1'b1) $display("FAIL fire_hold got %b want 1", mtip); else pass_cnt++;
    issue(1'b1, 5'h04, 32'hFFFF_FFFF, v, r, er);
    total++; if (mtip !== 1'b1) $display("FAIL fire_clear_n1 got %b want 1", mtip); else pass_cnt++;
    tick();
    total++; if (mtip !== 1'b0) $display("FAIL fire_clear_n2 got %b want 0", mtip); else pass_cnt++;
  endtask
  task automatic test_sw_irq();
    issue(1'b1, 5'h00, 32'hFFFF_FFFF, v, r, er);
    total++; if ({msip, v, r, er} !== {1'b1, 1'b1, 32'd0, 1'b0}) $display("FAIL msip_set got %b/%b/%h/%b want 1/1/0/0", msip, v, r, er); else pass_cnt++;
    issue(1'b0, 5'h00, 32'd0, v, r, er);
    total++; if (r !== 32'h0000_0001) $display("FAIL msip_read got %h want 00000001", r); else pass_cnt++;
    issue(1'b1, 5'h00, 32'd0, v, r, er);
    total++; if (msip !== 1'b0) $display("FAIL msip_clear got %b want 0", msip); else pass_cnt++;
  endtask
  task automatic test_wrap();
    issue(1'b1, 5'h08, 32'hFFFF_FFFF, v, r, er);
    issue(1'b1, 5'h10, 32'hFFFF_FFFF, v, r, er);
    issue(1'b1, 5'h0C, 32'hFFFF_FFFE, v, r, er);
    issue(1'b0, 5'h0C, 32'd0, v, r, er);
    total++; if (r !== 32'hFFFF_FFFE) $display("FAIL wrap_lo_written got %h want fffffffe", r); else pass_cnt++;
    issue(1'b0, 5'h10, 32'd0, v, r, er);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL wrap_hi_before got %h want ffffffff", r); else pass_cnt++;
    issue(1'b0, 5'h0C, 32'd0, v, r, er);
    total++; if (r !== 32'd0) $display("FAIL wrap_lo_after got %h want 0", r); else pass_cnt++;
    issue(1'b0, 5'h10, 32'd0, v, r, er);
    total++; if (r !== 32'd0) $display("FAIL wrap_hi_after got %h want 0", r); else pass_cnt++;
    total++; if (mtip !== 1'b0) $display("FAIL wrap_mtip got %b want 0", mtip); else pass_cnt++;
  endtask
  task automatic test_backpressure();
    bus.rsp_ready_in = 1'b0;
    issue(1'b0, 5'h0C, 32'd0, v, r0, er);
    total++; if ({v, bus.req_ready_out} !== 2'b10) $display("FAIL bp_first got %b want 10", {v, bus.req_ready_out}); else pass_cnt++;
    tick();
    total++; if ({bus.rsp_valid_out, bus.req_ready_out} !== 2'b10) $display("FAIL bp_hold got %b want 10", {bus.rsp_valid_out, bus.req_ready_out}); else pass_cnt++;
    total++; if (bus.rsp_rdata_out !== r0) $display("FAIL bp_stable got %h want %h", bus.rsp_rdata_out, r0); else pass_cnt++;
    bus.rsp_ready_in = 1'b1;
    #1;
    total++; if (bus.req_ready_out !== 1'b1) $display("FAIL bp_release got %b want 1", bus.req_ready_out); else pass_cnt++;
    tick();
    total++; if (bus.rsp_valid_out !== 1'b0) $display("FAIL bp_drain got %b want 0", bus.rsp_valid_out); else pass_cnt++;
    issue(1'b0, 5'h14, 32'd0, v, r, er);
    total++; if ({v, er, r} !== {1'b1, 1'b1, 32'd0}) $display("FAIL err_read got %b/%b/%h want 1/1/0", v, er, r); else pass_cnt++;
    issue(1'b1, 5'h02, 32'hFFFF_FFFF, v, r, er);
    total++; if ({er, r} !== {1'b1, 32'd0}) $display("FAIL err_write got %b/%h want 1/0", er, r); else pass_cnt++;
    issue(1'b0, 5'h00, 32'd0, v, r, er);
    total++; if ({er, r, msip} !== {1'b0, 32'd0, 1'b0}) $display("FAIL err_dropped got %b/%h/%b want 0/0/0", er, r, msip); else pass_cnt++;
  endtask
  task automatic test_snapshot();
    logic [31:0] exp_hi;
    issue(1'b1, 5'h10, 32'd0, v, r, er);
    issue(1'b1, 5'h0C, 32'hFFFF_FFF0, v, r, er);
    issue(1'b0, 5'h0C, 32'd0, v, r, er);
    total++; if (r !== 32'hFFFF_FFF0) $display("FAIL snap_lo got %h want fffffff0", r); else pass_cnt++;
    for (int k = 1; k <= 24; k++) begin
      issue(1'b0, 5'h10, 32'd0, v, r, er);
`ifdef CLINT_MTIME_SNAPSHOT_EN
      exp_hi = 32'd0;
`else
      exp_hi = (k >= 16) ? 32'd1 : 32'd0;
`endif
      total++; if (r !== exp_hi) $display("FAIL snap_hi k=%0d got %h want %h", k, r, exp_hi); else pass_cnt++;
    end
  endtask
  task automatic test_async_reset();
    issue(1'b1, 5'h00, 32'd1, v, r, er);
    bus.rsp_ready_in = 1'b0;
    issue(1'b0, 5'h04, 32'd0, v, r, er);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.rsp_valid_out, bus.req_ready_out, msip, mtip} !== 4'b0100) $display("FAIL async_reset got %b want 0100", {bus.rsp_valid_out, bus.req_ready_out, msip, mtip}); else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready_in = 1'b1;
    issue(1'b0, 5'h04, 32'd0, v, r, er);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL async_cmp_lo got %h want ffffffff", r); else pass_cnt++;
    issue(1'b0, 5'h08, 32'd0, v, r, er);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL async_cmp_hi got %h want ffffffff", r); else pass_cnt++;
    issue(1'b0, 5'h0C, 32'd0, v, r, er);
    total++; if (r !== 32'd2) $display("FAIL async_mtime got %h want 2", r); else pass_cnt++;
  endtask
  initial begin
    bus.req_valid_in = 1'b0;
    bus.req_we_in = 1'b0;
    bus.req_addr_in = 5'd0;
    bus.req_wdata_in = 32'd0;
    bus.rsp_ready_in = 1'b1;
    test_reset();
    test_timer_fire();
    test_sw_irq();
    test_wrap();
    test_backpressure();
    test_snapshot();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
